// File: rtl/pll_reconfig_seq.sv
// pll_reconfig_seq: gates the clock, holds the domain in reset, reloads one PLL's dividers and waits for lock.
// Optional macro PLL_SEQ_TIMEOUT_EN adds a WAIT_LOCK timeout (LOCK_TIMEOUT) that ends in ERR.
module pll_reconfig_seq #(
    parameter int REF_DIV_BW    = 4,
    parameter int FB_DIV_BW     = 12,
    parameter int RST_REF_DIV   = 1,
    parameter int RST_FB_DIV    = 40,
    parameter int GATE_CYCLES   = 2,
    parameter int LOCK_STABLE   = 16,
    parameter int UNGATE_CYCLES = 2
`ifdef PLL_SEQ_TIMEOUT_EN
    , parameter int LOCK_TIMEOUT = 4096
`endif
) (
    input  logic                  clk_i,
    input  logic                  arst_ni,
    input  logic                  cfg_valid_i,
    output logic                  cfg_ready_o,
    input  logic [REF_DIV_BW-1:0] cfg_ref_div_i,
    input  logic [FB_DIV_BW-1:0]  cfg_fb_div_i,
    output logic [REF_DIV_BW-1:0] pll_ref_div_o,
    output logic [FB_DIV_BW-1:0]  pll_fb_div_o,
    output logic                  pll_update_o,
    input  logic                  pll_lock_i,
    output logic                  clk_en_o,
    output logic                  dom_rst_no,
    output logic                  busy_o,
    output logic                  err_o
);

    localparam int PHASE_MAX = (GATE_CYCLES > UNGATE_CYCLES) ? GATE_CYCLES : UNGATE_CYCLES;
    localparam int PHASE_W   = $clog2(PHASE_MAX + 1);
    localparam int STABLE_W  = $clog2(LOCK_STABLE + 1);

    typedef enum logic [2:0] {IDLE, GATE, RESET, PROG, WAIT_LOCK, UNGATE, ERR} state_t;

    state_t                state, state_next;
    logic                  lock_meta, lock_sync;
    logic [PHASE_W-1:0]    phase_cnt, phase_cnt_next, phase_inc;
    logic [STABLE_W-1:0]   stable_cnt, stable_cnt_next, stable_inc;
    logic [REF_DIV_BW-1:0] req_ref;
    logic [FB_DIV_BW-1:0]  req_fb;
    logic                  accept, bad_req, err_next;

`ifdef PLL_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(LOCK_TIMEOUT + 1);
    logic [TO_W-1:0] timeout_cnt, timeout_cnt_next, timeout_inc;

    assign timeout_inc = (timeout_cnt == TO_W'(LOCK_TIMEOUT)) ? timeout_cnt : timeout_cnt + 1'b1;
`endif

    assign cfg_ready_o = (state == IDLE) || (state == ERR);
    assign busy_o      = !cfg_ready_o;
    assign accept      = cfg_valid_i && cfg_ready_o;
    assign bad_req     = (cfg_ref_div_i == '0) || (cfg_fb_div_i == '0);
    assign phase_inc   = (phase_cnt == PHASE_W'(PHASE_MAX)) ? phase_cnt : phase_cnt + 1'b1;
    assign stable_inc  = (stable_cnt == STABLE_W'(LOCK_STABLE)) ? stable_cnt : stable_cnt + 1'b1;

    // Counters fall back to zero in any state that does not use them, so each phase starts from 0.
    always_comb begin
        state_next      = state;
        phase_cnt_next  = '0;
        stable_cnt_next = '0;
        err_next        = err_o;
`ifdef PLL_SEQ_TIMEOUT_EN
        timeout_cnt_next = '0;
`endif
        case (state)
            IDLE, ERR: begin
                if (accept) begin
                    err_next   = bad_req;
                    state_next = bad_req ? IDLE : GATE;
                end
            end
            GATE: begin
                phase_cnt_next = phase_inc;
                if (phase_cnt == PHASE_W'(GATE_CYCLES - 1)) state_next = RESET;
            end
            RESET: state_next = PROG;
            PROG:  state_next = WAIT_LOCK;
            WAIT_LOCK: begin
                if (lock_sync) stable_cnt_next = stable_inc;
`ifdef PLL_SEQ_TIMEOUT_EN
                timeout_cnt_next = timeout_inc;
`endif
                if (lock_sync && (stable_inc == STABLE_W'(LOCK_STABLE))) begin
                    state_next = UNGATE;
                end
`ifdef PLL_SEQ_TIMEOUT_EN
                else if (timeout_cnt == TO_W'(LOCK_TIMEOUT - 1)) begin
                    state_next = ERR;
                    err_next   = 1'b1;
                end
`endif
            end
            UNGATE: begin
                phase_cnt_next = phase_inc;
                if (phase_cnt == PHASE_W'(UNGATE_CYCLES - 1)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Gate, reset and strobe outputs are registered from the next state so they never glitch.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state         <= IDLE;
            lock_meta     <= 1'b0;
            lock_sync     <= 1'b0;
            phase_cnt     <= '0;
            stable_cnt    <= '0;
            req_ref       <= REF_DIV_BW'(RST_REF_DIV);
            req_fb        <= FB_DIV_BW'(RST_FB_DIV);
            pll_ref_div_o <= REF_DIV_BW'(RST_REF_DIV);
            pll_fb_div_o  <= FB_DIV_BW'(RST_FB_DIV);
            pll_update_o  <= 1'b0;
            clk_en_o      <= 1'b1;
            dom_rst_no    <= 1'b1;
            err_o         <= 1'b0;
`ifdef PLL_SEQ_TIMEOUT_EN
            timeout_cnt   <= '0;
`endif
        end else begin
            state      <= state_next;
            lock_meta  <= pll_lock_i;
            lock_sync  <= lock_meta;
            phase_cnt  <= phase_cnt_next;
            stable_cnt <= stable_cnt_next;
            err_o      <= err_next;
`ifdef PLL_SEQ_TIMEOUT_EN
            timeout_cnt <= timeout_cnt_next;
`endif
            if (accept) begin
                req_ref <= cfg_ref_div_i;
                req_fb  <= cfg_fb_div_i;
            end
            if (state == RESET) begin
                pll_ref_div_o <= req_ref;
                pll_fb_div_o  <= req_fb;
            end
            pll_update_o <= (state_next == PROG);
            clk_en_o     <= (state_next == IDLE) || (state_next == UNGATE);
            dom_rst_no   <= (state_next == IDLE) || (state_next == GATE);
        end
    end

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Testbench for pll_reconfig_seq: randomized divider requests and lock profiles, with expected
// output events predicted from the sequencing rules and checked by an independent monitor.
module tb_pll_reconfig_seq;

    localparam int GATE_CYCLES   = 2;
    localparam int LOCK_STABLE   = 16;
    localparam int UNGATE_CYCLES = 2;
    localparam int MAXC          = 16384;

    typedef enum int {EV_ERRS, EV_ERRC, EV_GATE, EV_RSTA, EV_UPD, EV_UNG, EV_DONE} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       cyc;
        int       rdiv;
        int       fdiv;
    } ev_t;

    logic        clk_i = 1'b0;
    logic        arst_ni = 1'b0;
    logic        cfg_valid_i = 1'b0;
    logic        cfg_ready_o;
    logic [3:0]  cfg_ref_div_i = '0;
    logic [11:0] cfg_fb_div_i = '0;
    logic [3:0]  pll_ref_div_o;
    logic [11:0] pll_fb_div_o;
    logic        pll_update_o;
    logic        pll_lock_i = 1'b0;
    logic        clk_en_o;
    logic        dom_rst_no;
    logic        busy_o;
    logic        err_o;

    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;
    bit   lock_raw [MAXC];
    ev_t  q [$];

    // Reference model state: what the PLL outputs should hold and when the DUT is next free.
    int   cur_ref = 1;
    int   cur_fb = 40;
    bit   m_err = 1'b0;
    int   free_cyc = 0;

    logic p_clk = 1'b1, p_rst = 1'b1, p_busy = 1'b0, p_err = 1'b0;

    pll_reconfig_seq dut (
        .clk_i        (clk_i),
        .arst_ni      (arst_ni),
        .cfg_valid_i  (cfg_valid_i),
        .cfg_ready_o  (cfg_ready_o),
        .cfg_ref_div_i(cfg_ref_div_i),
        .cfg_fb_div_i (cfg_fb_div_i),
        .pll_ref_div_o(pll_ref_div_o),
        .pll_fb_div_o (pll_fb_div_o),
        .pll_update_o (pll_update_o),
        .pll_lock_i   (pll_lock_i),
        .clk_en_o     (clk_en_o),
        .dom_rst_no   (dom_rst_no),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic void check(input string name, input bit ok, input int act, input int exp);
        checks++;
        if (ok) passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Expected events for one accepted request, derived from the documented timeline.
    function automatic void predict(input int t0, input int r, input int f, input bit locks);
        int  w;
        int  u;
        bit  ok;
        if (r == 0 || f == 0) begin
            if (!m_err) q.push_back('{EV_ERRS, t0 + 1, cur_ref, cur_fb});
            m_err    = 1'b1;
            free_cyc = t0 + 1;
            return;
        end
        if (m_err) q.push_back('{EV_ERRC, t0 + 1, 0, 0});
        m_err = 1'b0;
        q.push_back('{EV_GATE, t0 + 1, 0, 0});
        q.push_back('{EV_RSTA, t0 + GATE_CYCLES + 1, 0, 0});
        q.push_back('{EV_UPD, t0 + GATE_CYCLES + 2, r, f});
        cur_ref = r;
        cur_fb  = f;
        if (!locks) begin
            free_cyc = MAXC;
            return;
        end
        // First WAIT_LOCK cycle is w; synced lock seen in cycle c is the raw value driven in c-2.
        w = t0 + GATE_CYCLES + 3;
        u = MAXC;
        for (int s = w + LOCK_STABLE; s < MAXC; s++) begin
            ok = 1'b1;
            for (int c = s - LOCK_STABLE; c < s; c++) if (!lock_raw[c - 2]) ok = 1'b0;
            if (ok) begin
                u = s;
                break;
            end
        end
        q.push_back('{EV_UNG, u, 0, 0});
        q.push_back('{EV_DONE, u + UNGATE_CYCLES, r, f});
        free_cyc = u + UNGATE_CYCLES;
    endfunction

    // mode 0: lock high, 1: drop on 10th WAIT_LOCK cycle, 2: random drops, 3: never locks
    task automatic plan_lock(input int t0, input int mode);
        int w;
        w = t0 + GATE_CYCLES + 3;
        for (int c = w - 2; c < w + 80; c++) lock_raw[c] = (mode != 3);
        if (mode == 1) lock_raw[w + 9 - 2] = 1'b0;
        if (mode == 2) begin
            for (int k = 0; k < 2; k++) lock_raw[int'($urandom_range(w + 24, w - 2))] = 1'b0;
        end
    endtask

    task automatic apply_stimulus(input int r, input int f, input int mode, output int t0);
        int guard;
        guard = 0;
        @(negedge clk_i);
        cfg_valid_i   = 1'b1;
        cfg_ref_div_i = 4'(r);
        cfg_fb_div_i  = 12'(f);
        t0 = (cyc > free_cyc) ? cyc : free_cyc;
        plan_lock(t0, mode);
        predict(t0, r, f, mode != 3);
        while (!cfg_ready_o && guard < 400) begin
            @(negedge clk_i);
            guard++;
        end
        check("accept_cycle", cfg_ready_o && cyc == t0, cyc, t0);
        @(negedge clk_i);
        cfg_valid_i = 1'b0;
    endtask

    task automatic check_output();
        check("rst_ref_div", pll_ref_div_o == 4'd1, int'(pll_ref_div_o), 1);
        check("rst_fb_div", pll_fb_div_o == 12'd40, int'(pll_fb_div_o), 40);
        check("rst_update", pll_update_o == 1'b0, int'(pll_update_o), 0);
        check("rst_clk_en", clk_en_o == 1'b1, int'(clk_en_o), 1);
        check("rst_dom_rst_n", dom_rst_no == 1'b1, int'(dom_rst_no), 1);
        check("rst_ready", cfg_ready_o == 1'b1, int'(cfg_ready_o), 1);
        check("rst_busy", busy_o == 1'b0, int'(busy_o), 0);
        check("rst_err", err_o == 1'b0, int'(err_o), 0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q.size() != 0 || busy_o) && n < 3000) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 3000) check("drain_timeout", 1'b0, q.size(), 0);
    endtask

    task automatic consume(input ev_kind_t k);
        ev_t e;
        if (q.size() == 0) begin
            check({"unexpected_", k.name()}, 1'b0, int'(k), -1);
            return;
        end
        e = q.pop_front();
        check({"event_kind_", e.kind.name()}, e.kind == k, int'(k), int'(e.kind));
        check({"event_cycle_", e.kind.name()}, e.cyc == cyc, cyc, e.cyc);
        if (k == EV_UPD || k == EV_DONE || k == EV_ERRS) begin
            check({"ref_div_", k.name()}, int'(pll_ref_div_o) == e.rdiv, int'(pll_ref_div_o), e.rdiv);
            check({"fb_div_", k.name()}, int'(pll_fb_div_o) == e.fdiv, int'(pll_fb_div_o), e.fdiv);
        end
        if (k == EV_UNG) check("ungate_reset_held", dom_rst_no == 1'b0, int'(dom_rst_no), 0);
        if (k == EV_DONE) check("done_ready", cfg_ready_o == 1'b1, int'(cfg_ready_o), 1);
    endtask

    // Monitor: turns output transitions into events and matches them against the queue.
    always @(negedge clk_i) begin
        if (!arst_ni) begin
            p_clk = 1'b1; p_rst = 1'b1; p_busy = 1'b0; p_err = 1'b0;
        end else begin
            if (err_o && !p_err) consume(EV_ERRS);
            if (!err_o && p_err) consume(EV_ERRC);
            if (!clk_en_o && p_clk) consume(EV_GATE);
            if (!dom_rst_no && p_rst) consume(EV_RSTA);
            if (pll_update_o) consume(EV_UPD);
            if (clk_en_o && !p_clk) consume(EV_UNG);
            if (!busy_o && p_busy) consume(EV_DONE);
            p_clk = clk_en_o; p_rst = dom_rst_no; p_busy = busy_o; p_err = err_o;
        end
    end

    initial forever begin
        @(negedge clk_i);
        pll_lock_i = (cyc < MAXC) ? lock_raw[cyc] : 1'b1;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got %0d, expected 0", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t0;
        int r;
        int f;
        for (int c = 0; c < MAXC; c++) lock_raw[c] = 1'b1;
        repeat (3) @(negedge clk_i);
        #2 arst_ni = 1'b1;
        @(negedge clk_i);
        check_output();

        apply_stimulus(2, 100, 0, t0);
        wait_idle();
        apply_stimulus(3, 200, 1, t0);
        wait_idle();

        apply_stimulus(0, 50, 0, t0);
        apply_stimulus(5, 0, 0, t0);
        apply_stimulus(4, 77, 0, t0);
        wait_idle();

        apply_stimulus(6, 300, 0, t0);
        repeat (3) @(negedge clk_i);
        check("busy_ready_low", !cfg_ready_o && busy_o, int'(cfg_ready_o), 0);
        apply_stimulus(7, 400, 2, t0);
        wait_idle();

        for (int i = 0; i < 8; i++) begin
            r = int'($urandom_range(15, 1));
            f = int'($urandom_range(4095, 1));
            if ($urandom_range(5, 0) == 0) begin
                if ($urandom_range(1, 0) == 0) r = 0;
                else f = 0;
            end
            apply_stimulus(r, f, int'($urandom_range(2, 0)), t0);
            if ($urandom_range(1, 0) == 0) wait_idle();
        end
        wait_idle();

        apply_stimulus(9, 500, 3, t0);
        while (cyc < t0 + GATE_CYCLES + 13) @(negedge clk_i);
        check("pre_reset_queue", q.size() == 0, q.size(), 0);
        check("pre_reset_busy", busy_o == 1'b1, int'(busy_o), 1);
        #2 arst_ni = 1'b0;
        #1 check_output();
        q.delete();
        cur_ref = 1; cur_fb = 40; m_err = 1'b0; free_cyc = 0;
        @(negedge clk_i);
        #2 arst_ni = 1'b1;

        apply_stimulus(3, 33, 0, t0);
        wait_idle();
        repeat (4) @(negedge clk_i);
        check("final_queue_empty", q.size() == 0, q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
